// File: rtl/sme_avst_to_axis.sv
// Avalon-ST (sop/eop/empty, byte 0 at MSBs) to little-endian AXI stream (tkeep/tlast) with skid buffer,
// framing FSM and error statistics. Define SME_DROP_BAD_EN to discard beats that arrive without a sop.
module sme_avst_to_axis #(
  parameter int BYTE_COUNT = 16,
  parameter int EMPTY_W    = $clog2(BYTE_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BYTE_COUNT*8-1:0] in_usr_data,
  input  logic                    in_usr_valid,
  output logic                    in_usr_ready,
  input  logic                    in_usr_sop,
  input  logic                    in_usr_eop,
  input  logic [EMPTY_W-1:0]      in_usr_empty,
  output logic [BYTE_COUNT*8-1:0] m_axis_tdata,
  output logic [BYTE_COUNT-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [31:0]             stat_pkt_count,
  output logic [15:0]             stat_err_count,
  output logic                    err_pulse
);

  localparam int DW = BYTE_COUNT * 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_PKT
`ifdef SME_DROP_BAD_EN
    , ST_DROP
`endif
  } state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_out_valid;
  logic [DW-1:0]     r_out_data;
  logic [BYTE_COUNT-1:0] r_out_keep;
  logic              r_out_last;
  logic              r_skid_valid;
  logic [DW-1:0]     r_skid_data;
  logic [BYTE_COUNT-1:0] r_skid_keep;
  logic              r_skid_last;
  logic [31:0]       r_pkt_cnt;
  logic [15:0]       r_err_cnt;
  logic              r_err_pulse;

  logic [DW-1:0]     w_beat_data;
  logic [BYTE_COUNT-1:0] w_beat_keep;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_out_free;
  logic              w_fwd;
  logic              w_err;
  logic              w_push;

  assign w_in_fire  = in_usr_valid & r_ready;
  assign w_out_fire = r_out_valid & m_axis_tready;
  assign w_out_free = ~r_out_valid | m_axis_tready;
  assign w_push     = w_in_fire & w_fwd;

  // Byte reversal plus tail masking; masked bytes are forced to zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_beat_data = '0;
    w_beat_keep = '0;
    for (int k = 0; k < BYTE_COUNT; k++) begin
      w_beat_keep[k] = ~in_usr_eop || (k < BYTE_COUNT - int'(in_usr_empty));
      if (w_beat_keep[k]) w_beat_data[k*8 +: 8] = in_usr_data[(BYTE_COUNT-1-k)*8 +: 8];
    end
  end

  always_comb begin
    w_err = 1'b0;
    w_fwd = 1'b1;
    if (w_in_fire) begin
      case (r_state)
        ST_IN_PKT: w_err = in_usr_sop;
`ifdef SME_DROP_BAD_EN
        ST_DROP: begin
          w_err = in_usr_sop;
          w_fwd = in_usr_sop;
        end
`endif
        default: begin
          w_err = ~in_usr_sop;
`ifdef SME_DROP_BAD_EN
          w_fwd = in_usr_sop;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      if (w_in_fire) begin
        if (in_usr_eop)     r_state <= ST_IDLE;
`ifdef SME_DROP_BAD_EN
        else if (!w_fwd)    r_state <= ST_DROP;
`endif
        else                r_state <= ST_IN_PKT;
      end
    end
  end

  // Output register plus one skid entry; ready is registered and mirrors an empty skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_pkt_cnt    <= '0;
    end else begin
      if (w_out_fire && r_out_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_out_free) begin
        r_ready <= 1'b1;
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_skid_data;
          r_out_keep   <= r_skid_keep;
          r_out_last   <= r_skid_last;
          r_skid_valid <= 1'b0;
        end else begin
          r_out_valid <= w_push;
          if (w_push) begin
            r_out_data <= w_beat_data;
            r_out_keep <= w_beat_keep;
            r_out_last <= in_usr_eop;
          end
        end
      end else if (w_push) begin
        r_skid_valid <= 1'b1;
        r_ready      <= 1'b0;
      end else begin
        r_ready <= ~r_skid_valid;
      end
    end
  end

  // NOTE: skid payload needs no reset; it is only observed while r_skid_valid is set.
  always_ff @(posedge clk) begin
    if (w_push && !w_out_free) begin
      r_skid_data <= w_beat_data;
      r_skid_keep <= w_beat_keep;
      r_skid_last <= in_usr_eop;
    end
  end

  assign in_usr_ready   = r_ready;
  assign m_axis_tvalid  = r_out_valid;
  assign m_axis_tdata   = r_out_data;
  assign m_axis_tkeep   = r_out_keep;
  assign m_axis_tlast   = r_out_last;
  assign stat_pkt_count = r_pkt_cnt;
  assign stat_err_count = r_err_cnt;
  assign err_pulse      = r_err_pulse;

endmodule

// File: tb/tb_sme_avst_to_axis.sv
// Self-checking bench for sme_avst_to_axis: directed vector table, framing corner cases and
// randomized traffic against a queue-based reference model.
module tb_sme_avst_to_axis;

  localparam int BC = 16;
  localparam int DW = BC * 8;
`ifdef SME_DROP_BAD_EN
  localparam int EXP_T4_PKTS = 1;
`else
  localparam int EXP_T4_PKTS = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_usr_data;
  logic          in_usr_valid;
  logic          in_usr_ready;
  logic          in_usr_sop;
  logic          in_usr_eop;
  logic [3:0]    in_usr_empty;
  logic [DW-1:0] m_axis_tdata;
  logic [BC-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [31:0]   stat_pkt_count;
  logic [15:0]   stat_err_count;
  logic          err_pulse;

  sme_avst_to_axis #(.BYTE_COUNT(BC)) dut (
    .clk(clk), .rst(rst),
    .in_usr_data(in_usr_data), .in_usr_valid(in_usr_valid), .in_usr_ready(in_usr_ready),
    .in_usr_sop(in_usr_sop), .in_usr_eop(in_usr_eop), .in_usr_empty(in_usr_empty),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .stat_pkt_count(stat_pkt_count), .stat_err_count(stat_err_count), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] tdata;
    logic [BC-1:0] tkeep;
    logic          tlast;
  } beat_t;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [3:0]    empty;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_data;
    logic [BC-1:0] exp_keep;
    logic          exp_last;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  beat_t       exp_q[$];
  logic [31:0] m_pkt_cnt;
  logic [15:0] m_err_cnt;
  bit          m_in_pkt;
  bit          m_drop;
  int          err_pulses;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: reverse byte order, keep BC-empty bytes on eop, zero the rest.
  function automatic beat_t ref_map(logic [DW-1:0] d, logic eop, logic [3:0] empty);
    beat_t b;
    int    nbytes;
    nbytes  = eop ? BC - int'(empty) : BC;
    b.tdata = '0;
    b.tkeep = '0;
    b.tlast = eop;
    for (int k = 0; k < nbytes; k++) begin
      b.tkeep[k]         = 1'b1;
      b.tdata[k*8 +: 8]  = d[DW-1-k*8 -: 8];
    end
    return b;
  endfunction

  task automatic model_accept(output bit err);
    bit fwd;
    fwd = 1'b1;
    err = in_usr_sop ? (m_in_pkt || m_drop) : !m_in_pkt;
`ifdef SME_DROP_BAD_EN
    fwd = in_usr_sop || m_in_pkt;
`endif
    if (fwd) begin
      exp_q.push_back(ref_map(in_usr_data, in_usr_eop, in_usr_empty));
      m_in_pkt = !in_usr_eop;
      m_drop   = 1'b0;
    end else begin
      m_in_pkt = 1'b0;
      m_drop   = !in_usr_eop;
    end
    if (err && m_err_cnt != 16'hFFFF) m_err_cnt++;
  endtask

  // One clock: score handshakes seen before the edge, then check DUT state #1 after it.
  task automatic step();
    bit    in_fire, out_fire, stall, exp_err;
    beat_t held, e;
    in_fire  = in_usr_valid && in_usr_ready;
    out_fire = m_axis_tvalid && m_axis_tready;
    stall    = m_axis_tvalid && !m_axis_tready;
    held     = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", m_axis_tvalid, 0);
      end else begin
        e = exp_q.pop_front();
        check("tdata", m_axis_tdata, e.tdata);
        check("tkeep", m_axis_tkeep, e.tkeep);
        check("tlast", m_axis_tlast, e.tlast);
        if (e.tlast) m_pkt_cnt++;
      end
    end
    exp_err = 1'b0;
    if (in_fire) model_accept(exp_err);
    @(posedge clk);
    #1;
    if (stall) begin
      check("stall_tvalid", m_axis_tvalid, 1);
      check("stall_tdata", m_axis_tdata, held.tdata);
      check("stall_tkeep", m_axis_tkeep, held.tkeep);
      check("stall_tlast", m_axis_tlast, held.tlast);
    end
    check("tvalid", m_axis_tvalid, exp_q.size() > 0);
    check("in_ready", in_usr_ready, exp_q.size() < 2);
    check("err_pulse", err_pulse, exp_err);
    check("err_count", stat_err_count, m_err_cnt);
    check("pkt_count", stat_pkt_count, m_pkt_cnt);
    if (err_pulse) err_pulses++;
  endtask

  task automatic send_beat(logic sop, logic eop, logic [3:0] empty, logic [DW-1:0] data, bit rand_ready);
    bit fired;
    in_usr_valid = 1'b1;
    in_usr_sop   = sop;
    in_usr_eop   = eop;
    in_usr_empty = empty;
    in_usr_data  = data;
    fired = 1'b0;
    for (int c = 0; c < 200 && !fired; c++) begin
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
      fired = in_usr_ready;
      step();
    end
    if (!fired) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    in_usr_valid = 1'b0;
  endtask

  task automatic drain();
    in_usr_valid  = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset(int cycles);
    rst          = 1'b1;
    in_usr_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_ready", in_usr_ready, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_pkt_count", stat_pkt_count, 0);
    check("rst_err_count", stat_err_count, 0);
    exp_q.delete();
    m_pkt_cnt  = '0;
    m_err_cnt  = '0;
    m_in_pkt   = 1'b0;
    m_drop     = 1'b0;
    err_pulses = 0;
    rst        = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int   rem;
    tbl[0] = '{1'b1, 1'b0, 4'd0, 128'h0102030405060708090A0B0C0D0E0F10,
               128'h100F0E0D0C0B0A090807060504030201, 16'hFFFF, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 4'd7, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF,
               128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 16'hFFFF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'd5, 128'h00112233445566778899AABBCCDDEEFF,
               128'h0000000000AA99887766554433221100, 16'h07FF, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 4'd0, 128'h000102030405060708090A0B0C0D0E0F,
               128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 4'd15, 128'hABCDEF0123456789ABCDEF0123456789,
               128'h000000000000000000000000000000AB, 16'h0001, 1'b1};

    rst           = 1'b1;
    in_usr_valid  = 1'b0;
    in_usr_sop    = 1'b0;
    in_usr_eop    = 1'b0;
    in_usr_empty  = '0;
    in_usr_data   = '0;
    m_axis_tready = 1'b1;
    do_reset(3);

    // Directed table: 3-beat packet with empty=5, single-beat packets incl. one-byte tail.
    for (int i = 0; i < 5; i++) begin
      send_beat(tbl[i].sop, tbl[i].eop, tbl[i].empty, tbl[i].data, 1'b0);
      check("tbl_tvalid", m_axis_tvalid, 1);
      check("tbl_tdata", m_axis_tdata, tbl[i].exp_data);
      check("tbl_tkeep", m_axis_tkeep, tbl[i].exp_keep);
      check("tbl_tlast", m_axis_tlast, tbl[i].exp_last);
    end
    drain();
    check("tbl_pkt_count", stat_pkt_count, 3);

    // Missing sop in IDLE followed by a good 2-beat packet.
    do_reset(1);
    send_beat(1'b0, 1'b1, 4'd3, 128'h11111111111111111111111111111111, 1'b0);
    send_beat(1'b1, 1'b0, 4'd0, 128'h22222222222222222222222222222222, 1'b0);
    send_beat(1'b0, 1'b1, 4'd2, 128'h33333333333333333333333333333333, 1'b0);
    drain();
    check("nosop_err_count", stat_err_count, 1);
    check("nosop_err_pulses", err_pulses, 1);
    check("nosop_pkt_count", stat_pkt_count, EXP_T4_PKTS);

    // Duplicate sop mid-packet: forwarded as continuation, one tlast at the real eop.
    do_reset(1);
    send_beat(1'b1, 1'b0, 4'd0, 128'h44444444444444444444444444444444, 1'b0);
    send_beat(1'b1, 1'b0, 4'd0, 128'h55555555555555555555555555555555, 1'b0);
    send_beat(1'b0, 1'b1, 4'd1, 128'h66666666666666666666666666666666, 1'b0);
    drain();
    check("dupsop_err_pulses", err_pulses, 1);
    check("dupsop_pkt_count", stat_pkt_count, 1);

    // Reset mid-packet while the output is stalled and the skid entry is full.
    m_axis_tready = 1'b0;
    send_beat(1'b1, 1'b0, 4'd0, 128'h77777777777777777777777777777777, 1'b0);
    send_beat(1'b0, 1'b0, 4'd0, 128'h88888888888888888888888888888888, 1'b0);
    check("stall_full_ready", in_usr_ready, 0);
    do_reset(1);
    send_beat(1'b1, 1'b1, 4'd4, 128'h99999999999999999999999999999999, 1'b0);
    drain();
    check("post_rst_pkt_count", stat_pkt_count, 1);
    check("post_rst_err_count", stat_err_count, 0);

    // 100 back-to-back beats of well-formed packets under random backpressure and gaps.
    do_reset(1);
    rem = 0;
    for (int i = 0; i < 100; i++) begin
      logic sop, eop;
      sop = (rem == 0);
      if (sop) rem = $urandom_range(1, 4);
      eop = (rem == 1);
      rem--;
      if ($urandom_range(0, 3) == 0) begin
        in_usr_valid  = 1'b0;
        m_axis_tready = 1'($urandom_range(0, 1));
        step();
      end
      send_beat(sop, eop, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end
    drain();

    // Random framing noise: sop/eop chosen freely, errors counted by the model.
    for (int i = 0; i < 60; i++) begin
      send_beat(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 4'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
